// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a word over a valid/ready load
// handshake and shifts it out one bit per shift_en tick on a registered line.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count_reg;
  logic             ser_out_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shift_next;

  // The register recirculates rather than zero-filling so every stored bit
  // stays in use; the wrapped bits are never sent because the counter ends
  // the frame first.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit  = load_data[WIDTH-1];
      assign shift_next = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]};
      assign next_bit   = shift_next[WIDTH-1];
    end else begin : g_lsb_first
      assign first_bit  = load_data[0];
      assign shift_next = {shift_reg[0], shift_reg[WIDTH-1:1]};
      assign next_bit   = shift_next[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      shift_reg   <= '0;
      ser_out_reg <= IDLE_LEVEL;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ser_out_reg <= IDLE_LEVEL;
          busy_reg    <= 1'b0;
          if (load_valid) begin
            shift_reg   <= load_data;
            count_reg   <= '0;
            ser_out_reg <= first_bit;
            busy_reg    <= 1'b1;
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (count_reg == LAST_BIT) begin
              ser_out_reg <= IDLE_LEVEL;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              state_reg   <= ST_IDLE;
            end else begin
              count_reg   <= count_reg + CW'(1);
              shift_reg   <= shift_next;
              ser_out_reg <= next_bit;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = (state_reg == ST_IDLE);
  assign ser_out    = ser_out_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first
// instance share stimulus; each scenario task checks its own results.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       shift_en;

  logic m_load_ready, m_ser_out, m_busy, m_done;
  logic l_load_ready, l_ser_out, l_busy, l_done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (m_load_ready),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .ser_out    (m_ser_out),
    .busy       (m_busy),
    .done       (m_done)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (l_load_ready),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .ser_out    (l_ser_out),
    .busy       (l_busy),
    .done       (l_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hC1;
    shift_en   = 1'b1;
    tick();
    tick();
    tests_run++;
    if (m_ser_out !== 1'b1) begin tests_failed++; $display("FAIL reset_ser_out: got %b expected 1", m_ser_out); end
    tests_run++;
    if (m_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
    tests_run++;
    if (m_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", m_done); end
    reset      = 1'b0;
    load_valid = 1'b0;
    shift_en   = 1'b0;
    tests_run++;
    if (m_load_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_load_ready: got %b expected 1", m_load_ready); end
    tick();
    tests_run++;
    if (m_busy !== 1'b0 || l_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_no_accept: busy got %b/%b expected 0/0", m_busy, l_busy);
    end
  endtask

  task automatic test_msb_frame();
    logic [7:0] seq = 8'b1100_0001;  // 0xC1 MSB-first, first bit at [7]
    load_valid = 1'b1;
    load_data  = 8'hC1;
    shift_en   = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (m_ser_out !== seq[7-k] || m_busy !== 1'b1 || m_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL msb_bit%0d: ser/busy/done got %b%b%b expected %b10", k, m_ser_out, m_busy, m_done, seq[7-k]);
      end
      tick();
    end
    tests_run++;
    if (m_ser_out !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b1) begin
      tests_failed++; $display("FAIL msb_done: ser/busy/done got %b%b%b expected 101", m_ser_out, m_busy, m_done);
    end
    shift_en = 1'b0;
    tick();
    tests_run++;
    if (m_done !== 1'b0) begin tests_failed++; $display("FAIL msb_done_width: got %b expected 0", m_done); end
  endtask

  task automatic test_lsb_frame();
    logic [7:0] seq = 8'b1000_0011;  // 0xC1 LSB-first, first bit at [7]
    int busy_cycles = 0;
    load_valid = 1'b1;
    load_data  = 8'hC1;
    shift_en   = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (l_busy === 1'b1) busy_cycles++;
        tests_run++;
        if (l_ser_out !== seq[7-k] || l_done !== 1'b0) begin
          tests_failed++;
          $display("FAIL lsb_bit%0d_c%0d: ser/done got %b%b expected %b0", k, c, l_ser_out, l_done, seq[7-k]);
        end
        shift_en = (c == 3);
        tick();
      end
    end
    shift_en = 1'b0;
    tests_run++;
    if (busy_cycles != 32) begin tests_failed++; $display("FAIL lsb_busy_cycles: got %0d expected 32", busy_cycles); end
    tests_run++;
    if (l_ser_out !== 1'b1 || l_busy !== 1'b0 || l_done !== 1'b1) begin
      tests_failed++; $display("FAIL lsb_done: ser/busy/done got %b%b%b expected 101", l_ser_out, l_busy, l_done);
    end
    tick();
    tests_run++;
    if (l_done !== 1'b0) begin tests_failed++; $display("FAIL lsb_done_width: got %b expected 0", l_done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq_a = 8'b0011_1100;  // 0x3C MSB-first
    logic [7:0] seq_b = 8'b1000_0001;  // 0x81 MSB-first
    load_valid = 1'b1;
    load_data  = 8'h3C;
    shift_en   = 1'b1;
    tick();
    load_data = 8'hFF;  // held valid while busy: must be ignored
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (m_ser_out !== seq_a[7-k] || m_load_ready !== 1'b0 || m_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL ignore_bit%0d: ser/ready/busy got %b%b%b expected %b01", k, m_ser_out, m_load_ready, m_busy, seq_a[7-k]);
      end
      tick();
    end
    tests_run++;
    if (m_done !== 1'b1 || m_load_ready !== 1'b1 || m_ser_out !== 1'b1 || m_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_gap: done/ready/ser/busy got %b%b%b%b expected 1110", m_done, m_load_ready, m_ser_out, m_busy);
    end
    load_data = 8'h81;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (m_ser_out !== seq_b[7-k] || m_busy !== 1'b1 || m_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_bit%0d: ser/busy/done got %b%b%b expected %b10", k, m_ser_out, m_busy, m_done, seq_b[7-k]);
      end
      tick();
    end
    tests_run++;
    if (m_done !== 1'b1 || m_busy !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_done: done/busy got %b%b expected 10", m_done, m_busy);
    end
    shift_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] seq_a = 8'b1010_0101;  // 0xA5 MSB-first
    logic [7:0] seq_b = 8'b0101_1010;  // 0x5A MSB-first
    load_valid = 1'b1;
    load_data  = 8'hA5;
    shift_en   = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (m_ser_out !== seq_a[7-k]) begin
        tests_failed++; $display("FAIL abort_bit%0d: got %b expected %b", k, m_ser_out, seq_a[7-k]);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    shift_en = 1'b0;
    tests_run++;
    if (m_ser_out !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0 || m_load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_state: ser/busy/done/ready got %b%b%b%b expected 1001", m_ser_out, m_busy, m_done, m_load_ready);
    end
    tick();
    tests_run++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      tests_failed++; $display("FAIL abort_no_done: done/busy got %b%b expected 00", m_done, m_busy);
    end
    load_valid = 1'b1;
    load_data  = 8'h5A;
    shift_en   = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (m_ser_out !== seq_b[7-k] || m_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL after_abort_bit%0d: ser/busy got %b%b expected %b1", k, m_ser_out, m_busy, seq_b[7-k]);
      end
      tick();
    end
    tests_run++;
    if (m_done !== 1'b1) begin tests_failed++; $display("FAIL after_abort_done: got %b expected 1", m_done); end
    shift_en = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [7:0] seq = 8'b1111_0000;  // 0xF0 MSB-first
    load_valid = 1'b1;
    load_data  = 8'hF0;
    shift_en   = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (m_ser_out !== seq[7-k] || m_busy !== 1'b1 || m_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_bit%0d: ser/busy/done got %b%b%b expected %b10", k, m_ser_out, m_busy, m_done, seq[7-k]);
      end
      if (k == 3) begin
        shift_en = 1'b0;
        for (int s = 0; s < 10; s++) begin
          tick();
          tests_run++;
          if (m_ser_out !== seq[7-k] || m_busy !== 1'b1 || m_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold%0d: ser/busy/done got %b%b%b expected %b10", s, m_ser_out, m_busy, m_done, seq[7-k]);
          end
        end
        shift_en = 1'b1;
      end
      tick();
    end
    tests_run++;
    if (m_done !== 1'b1 || m_busy !== 1'b0 || m_ser_out !== 1'b1) begin
      tests_failed++; $display("FAIL stall_done: done/busy/ser got %b%b%b expected 101", m_done, m_busy, m_ser_out);
    end
    shift_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_lsb_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parameterised parallel-in/serial-out transmitter that accepts a word over a valid/ready load handshake and shifts it out one bit per `shift_en` tick on a registered serial line. It is the transmit end of the serial links built from the team's flip-flop library, and it drives the matching serial-in/parallel-out receiver. It supports MSB-first or LSB-first ordering, a configurable idle line level and a one-cycle completion pulse.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2–32.
- `MSB_FIRST`, 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `IDLE_LEVEL`, 1'b1: value driven on `ser_out` when not transmitting.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  block can accept a word.
- `load_data`  in  WIDTH  word to transmit.
- `shift_en`  in  1  bit-rate tick; advances to the next bit when high in SHIFT.
- `ser_out`  out  1  serial data, driven directly from a flop.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse when the last bit's period ends.

## Operation
- States are IDLE and SHIFT. The block also holds these registers:
  - a shift register of `WIDTH` bits;
  - a bit counter of clog2(`WIDTH`) bits;
  - `ser_out`, `busy` and `done` flops.
- `load_ready` is combinational and equals (state == IDLE).
- **IDLE:**
  - `ser_out` = `IDLE_LEVEL`, `busy` = 0.
  - `shift_en` is ignored.
  - When `load_valid` is high, the word is accepted at that edge:
    - `load_data` is captured;
    - the counter is set to 0;
    - `ser_out` is set to the first bit (`load_data[WIDTH-1]` if `MSB_FIRST`, else `load_data[0]`);
    - `busy` is set to 1 and the state moves to SHIFT.
- **SHIFT:**
  - `shift_en` = 0: all state holds. `ser_out` holds the current bit indefinitely.
  - `shift_en` = 1 and counter < `WIDTH-1`:
    - the counter increments;
    - the shift register shifts toward the output end;
    - `ser_out` is set to the next bit.
  - `shift_en` = 1 and counter == `WIDTH-1`:
    - `ser_out` is set to `IDLE_LEVEL`, `busy` to 0, `done` to 1;
    - the state moves to IDLE.
- `done` is high for exactly one cycle. It is cleared on the next edge unless that edge itself completes a frame, which cannot happen because a frame takes at least `WIDTH` edges.
- `load_valid` and `load_data` are ignored in SHIFT. A word is never overwritten mid-frame.
- **Reset** has priority over every other event:
  - state = IDLE, counter = 0, shift register = 0;
  - `ser_out` = `IDLE_LEVEL`, `busy` = 0, `done` = 0.
  - A frame in progress is aborted without a `done` pulse.

## Timing
- Reset values:
  - `ser_out` = `IDLE_LEVEL`;
  - `busy` = 0, `done` = 0;
  - `load_ready` = 1 from the first cycle after reset is released. While `reset` is high, `load_ready` reads 1 but acceptance is blocked.
- Load latency: the accept edge is E0. Bit 0 of the frame appears on `ser_out` immediately after E0.
- `shift_en` sampled high at E0 is not counted. The first counted tick is at an edge after E0.
- Bit k (k = 0..`WIDTH-1`) is held on `ser_out` from the (k)th counted tick edge until the (k+1)th counted tick edge; bit 0 starts at E0.
- With `shift_en` tied high, a frame lasts exactly `WIDTH` cycles of `busy` = 1.
- `done` and `busy` fall coincide with the last tick edge.
- Back-to-back frames:
  - `load_ready` = 1 in the cycle `done` is high.
  - A word presented then is accepted at the next edge.
  - The minimum gap between frames is therefore one cycle at `IDLE_LEVEL`.
- A tick on the same edge as reset is discarded.
- A load on the same edge as reset is discarded.

## Test plan
- Reset check: hold `reset` high for 2 cycles with `load_valid` = 1 and `shift_en` = 1. Required: `ser_out` = 1, `busy` = 0, `done` = 0, no acceptance. After release, `load_ready` = 1.
- MSB-first frame (`WIDTH` = 8, `MSB_FIRST` = 1), `load_data` = 0xC1, `shift_en` tied high:
  - `ser_out` = 1,1,0,0,0,0,0,1 on the 8 cycles after the accept edge, with `busy` = 1 throughout;
  - then `ser_out` = 1, `busy` = 0 and `done` = 1 for exactly one cycle.
- LSB-first frame (`MSB_FIRST` = 0), `load_data` = 0xC1, `shift_en` pulsing one cycle in four:
  - `ser_out` = 1,0,0,0,0,0,1,1, each bit held 4 cycles;
  - `done` pulses once, after 32 cycles of `busy`.
- Load ignored while busy: present 0x3C, then while `busy` = 1 drive `load_valid` high with 0xFF.
  - Required: the serial output is exactly 0x3C's bits, and `load_ready` = 0 during the frame.
  - Back-to-back variant: 0x3C is accepted, then in the cycle `done` = 1 present 0x81. 0x81 is accepted at the next edge, with exactly one `IDLE_LEVEL` cycle between frames.
- Reset mid-frame: assert `reset` for one cycle after 3 bits of 0xA5.
  - Required: the next cycle shows `ser_out` = `IDLE_LEVEL`, `busy` = 0 and no `done` pulse.
  - A subsequent load of 0x5A transmits correctly from bit 0.
- `shift_en` stall: start the frame for 0xF0 and hold `shift_en` = 0 for 10 cycles mid-frame.
  - Required: `ser_out` and `busy` are held, `done` stays 0, and the frame resumes from the same bit.
